// File: rtl/sdram_word_bridge.sv
// sdram_word_bridge: turns single-word CPU reads/writes into line transactions
// on a 256-bit start/done line port. Word writes are read-modify-write.
// Optional line buffer: define SDRAM_LINE_BUF_EN to keep the last line touched
// (tag + valid) so that hits skip the controller read.
module sdram_word_bridge #(
   parameter int LINE_ADDR_BITS = 21,
   parameter int WORD_BITS      = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [LINE_ADDR_BITS+2:0] word_addr,
   input  logic [WORD_BITS-1:0]      word_data,
   input  logic                      word_we,
   input  logic                      word_start,
   output logic                      word_done,
   output logic [WORD_BITS-1:0]      word_q,
   output logic                      busy,
   output logic [LINE_ADDR_BITS-1:0] sdc_addr,
   output logic [8*WORD_BITS-1:0]    sdc_data,
   output logic                      sdc_we,
   output logic                      sdc_start,
   input  logic                      sdc_done,
   input  logic [8*WORD_BITS-1:0]    sdc_q
);

   localparam int LINE_BITS = 8 * WORD_BITS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_MERGE,
      S_WR_REQ,
      S_WR_WAIT,
      S_DONE
   } state_t;

   state_t                      state_q;
   logic                        word_done_q;
   logic [WORD_BITS-1:0]        rd_word_q;
   logic                        busy_q;
   logic [LINE_ADDR_BITS-1:0]   sdc_addr_q;
   logic [LINE_BITS-1:0]        sdc_data_q;
   logic                        sdc_we_q;
   logic                        sdc_start_q;

   // Request latched at acceptance; line_q holds the captured (or buffered) line.
   logic [2:0]                  req_off_q;
   logic [WORD_BITS-1:0]        req_data_q;
   logic                        req_we_q;
   logic [LINE_BITS-1:0]        line_q;
   logic [LINE_BITS-1:0]        line_d;
   logic                        buf_hit;

`ifdef SDRAM_LINE_BUF_EN
   logic                        buf_vld_q;
   logic [LINE_ADDR_BITS-1:0]   buf_tag_q;
   assign buf_hit = buf_vld_q && (buf_tag_q == word_addr[LINE_ADDR_BITS+2:3]);
`else
   assign buf_hit = 1'b0;
`endif

   // Word offset 0 is the most significant word of the line.
   function automatic logic [WORD_BITS-1:0] get_word(input logic [LINE_BITS-1:0] line,
                                                     input logic [2:0]           off);
      return line[(7 - int'(off)) * WORD_BITS +: WORD_BITS];
   endfunction

   function automatic logic [LINE_BITS-1:0] put_word(input logic [LINE_BITS-1:0] line,
                                                     input logic [2:0]           off,
                                                     input logic [WORD_BITS-1:0] w);
      logic [LINE_BITS-1:0] r;
      r = line;
      r[(7 - int'(off)) * WORD_BITS +: WORD_BITS] = w;
      return r;
   endfunction

   assign line_d = put_word(line_q, req_off_q, req_data_q);

   // Request FSM with registered outputs; controller signals are held from
   // sdc_start until sdc_done because they only change on state entry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         word_done_q <= 1'b0;
         rd_word_q   <= '0;
         busy_q      <= 1'b0;
         sdc_addr_q  <= '0;
         sdc_data_q  <= '0;
         sdc_we_q    <= 1'b0;
         sdc_start_q <= 1'b0;
`ifdef SDRAM_LINE_BUF_EN
         buf_vld_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (word_start) begin
                  req_off_q  <= word_addr[2:0];
                  req_data_q <= word_data;
                  req_we_q   <= word_we;
                  sdc_addr_q <= word_addr[LINE_ADDR_BITS+2:3];
                  busy_q     <= 1'b1;
                  if (buf_hit && !word_we) begin
                     rd_word_q   <= get_word(line_q, word_addr[2:0]);
                     word_done_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else if (buf_hit) begin
                     state_q     <= S_MERGE;
                  end else begin
                     sdc_we_q    <= 1'b0;
                     sdc_start_q <= 1'b1;
                     state_q     <= S_RD_REQ;
                  end
               end
            end
            S_RD_REQ: begin
               sdc_start_q <= 1'b0;
               state_q     <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (sdc_done) begin
                  line_q <= sdc_q;
`ifdef SDRAM_LINE_BUF_EN
                  buf_vld_q <= 1'b1;
                  buf_tag_q <= sdc_addr_q;
`endif
                  if (req_we_q) begin
                     state_q <= S_MERGE;
                  end else begin
                     rd_word_q   <= get_word(sdc_q, req_off_q);
                     word_done_q <= 1'b1;
                     state_q     <= S_DONE;
                  end
               end
            end
            S_MERGE: begin
               line_q      <= line_d;
               sdc_data_q  <= line_d;
               sdc_we_q    <= 1'b1;
               sdc_start_q <= 1'b1;
               state_q     <= S_WR_REQ;
            end
            S_WR_REQ: begin
               sdc_start_q <= 1'b0;
               state_q     <= S_WR_WAIT;
            end
            S_WR_WAIT: begin
               if (sdc_done) begin
                  word_done_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               word_done_q <= 1'b0;
               busy_q      <= 1'b0;
               sdc_we_q    <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign word_done = word_done_q;
   assign word_q    = rd_word_q;
   assign busy      = busy_q;
   assign sdc_addr  = sdc_addr_q;
   assign sdc_data  = sdc_data_q;
   assign sdc_we    = sdc_we_q;
   assign sdc_start = sdc_start_q;

endmodule

// File: tb/tb_sdram_word_bridge.sv
// Bench for sdram_word_bridge: a behavioural line-memory responder on the
// controller side and a word-addressed reference memory on the CPU side.
module tb_sdram_word_bridge;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [23:0]   word_addr = '0;
   logic [31:0]   word_data = '0;
   logic          word_we = 1'b0;
   logic          word_start = 1'b0;
   logic          word_done;
   logic [31:0]   word_q;
   logic          busy;
   logic [20:0]   sdc_addr;
   logic [255:0]  sdc_data;
   logic          sdc_we;
   logic          sdc_start;
   logic          sdc_done = 1'b0;
   logic [255:0]  sdc_q = '0;

   sdram_word_bridge dut (
      .clk        (clk),
      .reset      (reset),
      .word_addr  (word_addr),
      .word_data  (word_data),
      .word_we    (word_we),
      .word_start (word_start),
      .word_done  (word_done),
      .word_q     (word_q),
      .busy       (busy),
      .sdc_addr   (sdc_addr),
      .sdc_data   (sdc_data),
      .sdc_we     (sdc_we),
      .sdc_start  (sdc_start),
      .sdc_done   (sdc_done),
      .sdc_q      (sdc_q)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Backing-store initial contents, defined per word.
   function automatic logic [31:0] init_word(input logic [23:0] a);
      return ({8'd0, a} * 32'h9E3779B1) ^ 32'hC3A50F1E;
   endfunction

   // Controller side: line store, offset 0 is the most significant word.
   logic [255:0] line_mem [logic [20:0]];

   function automatic logic [255:0] get_line(input logic [20:0] la);
      logic [255:0] l;
      if (line_mem.exists(la)) return line_mem[la];
      for (int k = 0; k < 8; k++) l[255 - 32*k -: 32] = init_word({la, 3'(k)});
      return l;
   endfunction

   // CPU side reference: plain word memory plus last-line tracking.
   logic [31:0] ref_mem [logic [23:0]];
   logic [31:0] last_q = '0;
   bit          mbuf_vld = 0;
   logic [20:0] mbuf_tag = '0;

   function automatic logic [31:0] ref_read(input logic [23:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   // Responder: random latency, one outstanding transaction, checks stability.
   int          cyc = 0;
   int          start_cnt = 0;
   int          last_done_cyc = -10;
   int          force_delay = 0;
   bit          pend = 0;
   bit          abandoned = 0;
   bit          prev_start = 0;
   int          cnt = 0;
   logic [20:0] p_addr;
   logic [255:0] p_data;
   logic        p_we;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && pend) abandoned = 1;
   end

   always @(negedge clk) begin
      if (sdc_done) begin
         sdc_done = 1'b0;
         pend = 0;
      end else if (pend) begin
         if (!abandoned) begin
            chk("sdc_addr_stable", sdc_addr, p_addr);
            chk("sdc_we_stable", sdc_we, p_we);
            if (p_we) chk("sdc_data_stable", sdc_data, p_data);
         end
         if (cnt > 1) cnt--;
         else begin
            if (p_we) line_mem[p_addr] = p_data;
            sdc_q = get_line(p_addr);
            sdc_done = 1'b1;
            last_done_cyc = cyc;
         end
      end
      if (sdc_start) begin
         start_cnt++;
         chk("start_width", prev_start, 0);
         chk("start_overlap", pend, 0);
         pend = 1;
         abandoned = 0;
         cnt = (force_delay != 0) ? force_delay : int'($urandom_range(1, 4));
         p_addr = sdc_addr;
         p_data = sdc_data;
         p_we = sdc_we;
      end
      prev_start = sdc_start;
   end

   // One word request, checked against the reference model.
   // mode 1: extra word_start while busy; mode 2: extra word_start in the done cycle.
   task automatic req(input bit we, input logic [23:0] a, input logic [31:0] d,
                      input int mode, output logic [31:0] q);
      int s0, n, exp_st;
      bit hit, seen;
      logic [31:0] exp_rd;
      hit = 0;
`ifdef SDRAM_LINE_BUF_EN
      hit = mbuf_vld && (mbuf_tag == a[23:3]);
`endif
      exp_st = we ? (hit ? 1 : 2) : (hit ? 0 : 1);
      exp_rd = ref_read(a);
      word_addr = a; word_data = d; word_we = we; word_start = 1'b1;
      s0 = start_cnt;
      @(negedge clk);
      word_start = 1'b0;
      chk("busy_set", busy, 1);
      if (mode == 1) begin
         word_addr = a ^ 24'h000555; word_data = ~d; word_we = ~we; word_start = 1'b1;
      end
      seen = 0;
      n = 1;
      while (!seen && n < 60) begin
         if (word_done) seen = 1;
         else begin
            @(negedge clk);
            word_start = 1'b0;
            n++;
         end
      end
      chk("done_timeout", seen, 1);
      if (seen) begin
         if (exp_st == 0) chk("hit_latency", n, 1);
         else chk("done_latency", cyc, last_done_cyc + 1);
         chk("sdc_starts", start_cnt - s0, exp_st);
         if (!we) chk("word_q", word_q, exp_rd);
         else chk("word_q_hold", word_q, last_q);
      end
      q = word_q;
      if (mode == 2) begin
         word_addr = a ^ 24'h000AAA; word_data = ~d; word_we = ~we; word_start = 1'b1;
      end
      @(negedge clk);
      word_start = 1'b0;
      chk("done_pulse", word_done, 0);
      chk("busy_drop", busy, 0);
      if (mode != 0) begin
         s0 = start_cnt;
         repeat (4) @(negedge clk);
         chk("ignored_start", start_cnt - s0, 0);
         chk("idle_busy", busy, 0);
      end
      if (we) ref_mem[a] = d;
      else last_q = exp_rd;
      mbuf_vld = 1;
      mbuf_tag = a[23:3];
   endtask

   typedef struct {
      bit          we;
      logic [23:0] addr;
      logic [31:0] data;
      int          mode;
      bit          has_q;
      logic [31:0] exp_q;
   } vec_t;

   vec_t vt [10];

   initial begin
      #500us;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [31:0]  q;
      logic [255:0] ln;
      logic [20:0]  rl;
      bit           bad;

      vt[0] = '{1'b1, 24'h000010, 32'hAAAA0001, 1, 1'b0, 32'h0};
      vt[1] = '{1'b0, 24'h000010, 32'h0,        0, 1'b1, 32'hAAAA0001};
      vt[2] = '{1'b0, 24'h000017, 32'h0,        2, 1'b1, init_word(24'h000017)};
      vt[3] = '{1'b1, 24'hFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 32'h0};
      vt[4] = '{1'b0, 24'hFFFFFF, 32'h0,        0, 1'b1, 32'hFFFFFFFF};
      vt[5] = '{1'b0, 24'hFFFFF8, 32'h0,        0, 1'b1, init_word(24'hFFFFF8)};
      vt[6] = '{1'b0, 24'h000000, 32'h0,        0, 1'b1, init_word(24'h000000)};
      vt[7] = '{1'b1, 24'h000087, 32'hCAFEBABE, 2, 1'b0, 32'h0};
      vt[8] = '{1'b0, 24'h000083, 32'h0,        0, 1'b1, 32'h12345678};
      vt[9] = '{1'b0, 24'h000087, 32'h0,        1, 1'b1, 32'hCAFEBABE};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {word_done, busy, sdc_we, sdc_start}, 4'b0000);
      chk("reset_word_q", word_q, 0);
      chk("reset_sdc_addr", sdc_addr, 0);
      chk("reset_sdc_data", sdc_data, 0);
      reset = 1'b1;
      @(negedge clk);

      // Word write into line 16, offset 3
      req(1'b1, 24'h000083, 32'h12345678, 0, q);
      ln = get_line(21'd16);
      chk("line16_w3", ln[159:128], 32'h12345678);
      for (int k = 0; k < 8; k++)
         if (k != 3) chk("line16_other", ln[255 - 32*k -: 32], init_word({21'd16, 3'(k)}));

      // Read it back, then a neighbour in the same line (buffer hit when enabled)
      req(1'b0, 24'h000083, 32'h0, 0, q);
      chk("read_83", q, 32'h12345678);
      req(1'b0, 24'h000081, 32'h0, 0, q);
      chk("read_81", q, init_word(24'h000081));

      // Vector table
      for (int i = 0; i < 10; i++) begin
         req(vt[i].we, vt[i].addr, vt[i].data, vt[i].mode, q);
         if (vt[i].has_q) chk("table_q", q, vt[i].exp_q);
      end

      // Top line: only the last word touched, line 0 never written
      ln = get_line(21'h1FFFFF);
      chk("top_w7", ln[31:0], 32'hFFFFFFFF);
      for (int k = 0; k < 7; k++)
         chk("top_other", ln[255 - 32*k -: 32], init_word({21'h1FFFFF, 3'(k)}));
      chk("no_wrap_line0", line_mem.exists(21'd0), 0);

      // Reset while waiting for the controller read
      force_delay = 6;
      word_addr = 24'h000080; word_we = 1'b0; word_start = 1'b1;
      @(negedge clk);
      word_start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_ctrl", {word_done, busy, sdc_we, sdc_start}, 4'b0000);
      chk("rst_mid_word_q", word_q, 0);
      chk("rst_mid_addr", sdc_addr, 0);
      chk("rst_mid_data", sdc_data, 0);
      reset = 1'b1;
      mbuf_vld = 0;
      last_q = '0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (word_done || busy || sdc_start) bad = 1;
      end
      chk("late_done_dropped", bad, 0);
      force_delay = 0;
      req(1'b0, 24'h000080, 32'h0, 0, q);
      chk("read_80_after_rst", q, init_word(24'h000080));

      // Random traffic over a few lines so hits and misses mix
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0: rl = 21'd16;
            1: rl = 21'd17;
            2: rl = 21'h1FFFFF;
            default: rl = 21'($urandom());
         endcase
         req(1'($urandom_range(0, 1)), {rl, 3'($urandom_range(0, 7))}, $urandom(),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0, q);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
